// File: rtl/sprite_pkg.sv
// Purpose: shared constants, field slices and state encoding for the sprite pipeline.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sprite_pkg;

    localparam int SPRITE_DIM = 8;
    localparam int LOG2_DIM   = $clog2(SPRITE_DIM);
    localparam int COLOR_W    = 8;
    localparam int IMG_W      = 8;
    localparam int ADDR_W     = IMG_W + 2 * LOG2_DIM;

    localparam int SCREEN_W   = 320;
    localparam int SCREEN_H   = 240;

    localparam logic [COLOR_W-1:0] TRANSPARENT = 8'h00;

    // Packed coordinate layout {x[8:0], y[7:0]}, shared with the movement stage
    localparam int X_MSB = 16;
    localparam int X_LSB = 8;
    localparam int Y_MSB = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        WAIT    = 3'd2,
        WRITE   = 3'd3,
        ADVANCE = 3'd4
    } draw_state_t;

endpackage

// File: rtl/sprite_draw_engine_pixel_counter.sv
// Purpose: row-major row/col cursor over one sprite block, with look-ahead of the next position.
// Latency: cursor moves one cycle after advance; next-position outputs are combinational.
// Backpressure: none; the owner decides when to advance.
module sprite_pixel_counter
    import sprite_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                advance,
    output logic [LOG2_DIM-1:0] row,
    output logic [LOG2_DIM-1:0] col,
    output logic [LOG2_DIM-1:0] nxt_row,
    output logic [LOG2_DIM-1:0] nxt_col,
    output logic                last_pixel
);

    localparam logic [LOG2_DIM-1:0] LAST = '1;
    localparam logic [LOG2_DIM-1:0] ONE  = LOG2_DIM'(1);

    // Next cursor position: column wraps into the following row
    always_comb begin
        nxt_col = col + ONE;
        nxt_row = row;
        if (col == LAST) begin
            nxt_col = '0;
            nxt_row = row + ONE;
        end
    end

    assign last_pixel = (row == LAST) && (col == LAST);

    // Cursor register: clear on a new command, step on each retired pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            row <= nxt_row;
            col <= nxt_col;
        end
    end

endmodule

// File: rtl/sprite_draw_engine.sv
// Purpose: walk one sprite image in ROM and write its visible, opaque pixels to the frame buffer.
// Latency: 3 cycles per skipped pixel, 4 cycles plus fb stall per written pixel.
// Backpressure: WRITE holds all fb_* outputs until fb_rdy; no new command while busy.
module sprite_draw_engine
    import sprite_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               draw_sprite_start,
    input  logic [IMG_W-1:0]   draw_sprite_image,
    input  logic [16:0]        draw_sprite_coordinates,
    output logic               draw_sprite_rdy,
    output logic               draw_done,
    output logic               rom_re,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               fb_we,
    output logic [8:0]         fb_x,
    output logic [7:0]         fb_y,
    output logic [COLOR_W-1:0] fb_color,
    input  logic               fb_rdy
);

    localparam logic [9:0] X_LIMIT = 10'(SCREEN_W);
    localparam logic [8:0] Y_LIMIT = 9'(SCREEN_H);

    draw_state_t         state;
    logic [IMG_W-1:0]    image;
    logic [8:0]          base_x;
    logic [7:0]          base_y;
    logic [LOG2_DIM-1:0] row;
    logic [LOG2_DIM-1:0] col;
    logic [LOG2_DIM-1:0] nxt_row;
    logic [LOG2_DIM-1:0] nxt_col;
    logic                last_pixel;
    logic                accept;
    logic                step;
    logic [9:0]          px;
    logic [8:0]          py;
    logic                skip;

    assign accept = (state == IDLE) && draw_sprite_start;
    assign step   = (state == ADVANCE);

    sprite_pixel_counter u_cursor (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept),
        .advance    (step),
        .row        (row),
        .col        (col),
        .nxt_row    (nxt_row),
        .nxt_col    (nxt_col),
        .last_pixel (last_pixel)
    );

    // Screen position is one bit wider than the axis so a sprite straddling the edge clips instead of wrapping
    assign px   = {1'b0, base_x} + {{(10 - LOG2_DIM){1'b0}}, col};
    assign py   = {1'b0, base_y} + {{(9 - LOG2_DIM){1'b0}}, row};
    // One verdict covers transparency and both edges, so a pixel is retired exactly once
    assign skip = (rom_data == TRANSPARENT) || (px >= X_LIMIT) || (py >= Y_LIMIT);

    // Draw sequencer; every output is registered and set on the transition into the state that owns it.
    // The ROM read data is forwarded straight into fb_color when the write is launched, so no separate pixel latch is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            image           <= '0;
            base_x          <= '0;
            base_y          <= '0;
            draw_sprite_rdy <= 1'b1;
            draw_done       <= 1'b0;
            rom_re          <= 1'b0;
            rom_addr        <= '0;
            fb_we           <= 1'b0;
            fb_x            <= '0;
            fb_y            <= '0;
            fb_color        <= '0;
        end else begin
            draw_done <= 1'b0;
            rom_re    <= 1'b0;
            case (state)
                IDLE: begin
                    if (draw_sprite_start) begin
                        image           <= draw_sprite_image;
                        base_x          <= draw_sprite_coordinates[X_MSB:X_LSB];
                        base_y          <= draw_sprite_coordinates[Y_MSB:0];
                        draw_sprite_rdy <= 1'b0;
                        rom_re          <= 1'b1;
                        rom_addr        <= {draw_sprite_image, {(2 * LOG2_DIM){1'b0}}};
                        state           <= READ;
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (skip) begin
                        draw_done <= last_pixel;
                        state     <= ADVANCE;
                    end else begin
                        fb_we    <= 1'b1;
                        fb_x     <= px[8:0];
                        fb_y     <= py[7:0];
                        fb_color <= rom_data;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (fb_rdy) begin
                        fb_we     <= 1'b0;
                        draw_done <= last_pixel;
                        state     <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (last_pixel) begin
                        draw_sprite_rdy <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        rom_re   <= 1'b1;
                        rom_addr <= {image, nxt_row, nxt_col};
                        state    <= READ;
                    end
                end
                default: begin
                    draw_sprite_rdy <= 1'b1;
                    fb_we           <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Purpose: randomized scoreboard bench for sprite_draw_engine against a pixel-list reference model.
// Latency: expected draw time derived from skip/write counts plus the stalls the bench inserts.
// Backpressure: bench-side frame buffer stalls fb_rdy per write from a stall plan.
module tb_sprite_draw_engine;

    localparam int DIM = 8;
    localparam int SW  = 320;
    localparam int SH  = 240;

    typedef struct {
        int x;
        int y;
        int c;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        draw_sprite_start;
    logic [7:0]  draw_sprite_image;
    logic [16:0] draw_sprite_coordinates;
    logic        draw_sprite_rdy;
    logic        draw_done;
    logic        rom_re;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data;
    logic        fb_we;
    logic [8:0]  fb_x;
    logic [7:0]  fb_y;
    logic [7:0]  fb_color;
    logic        fb_rdy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          rom_mode = 0;
    int unsigned rom_seed = 0;
    int          wr_seen = 0;
    int          stall_total = 0;
    int          last_done_at = 0;
    int          last_writes = 0;
    int          addr_q[$];
    wr_t         wr_q[$];
    int          stall_q[$];

    sprite_draw_engine dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .draw_sprite_start       (draw_sprite_start),
        .draw_sprite_image       (draw_sprite_image),
        .draw_sprite_coordinates (draw_sprite_coordinates),
        .draw_sprite_rdy         (draw_sprite_rdy),
        .draw_done               (draw_done),
        .rom_re                  (rom_re),
        .rom_addr                (rom_addr),
        .rom_data                (rom_data),
        .fb_we                   (fb_we),
        .fb_x                    (fb_x),
        .fb_y                    (fb_y),
        .fb_color                (fb_color),
        .fb_rdy                  (fb_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ROM image contents; a is the flat address image*64 + row*8 + col
    function automatic logic [7:0] rom_fn(input int a);
        int unsigned h;
        case (rom_mode)
            0: return 8'h5A;
            1: return (((a % DIM) % 2) == 0) ? 8'h00 : 8'h5A;
            default: begin
                h = a;
                h = h * 32'h9E3779B1 + rom_seed;
                h = h ^ (h >> 15);
                if ((h % 4) == 0) return 8'h00;
                return 8'((h >> 4) % 256);
            end
        endcase
    endfunction

    // Sprite ROM: data valid one cycle after the read enable
    always @(posedge clk) begin
        if (rom_re) rom_data <= rom_fn(int'(rom_addr));
    end

    // Frame buffer responder: stalls each write by the next planned amount
    initial begin : fb_resp
        int stall_left;
        bit in_wr;
        fb_rdy = 1'b1;
        in_wr = 0;
        stall_left = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!fb_we) begin
                in_wr = 0;
                fb_rdy = 1'($urandom_range(0, 1));
            end else begin
                if (!in_wr) begin
                    in_wr = 1;
                    stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
                end
                if (stall_left > 0) begin
                    fb_rdy = 1'b0;
                    stall_left--;
                    stall_total++;
                end else begin
                    fb_rdy = 1'b1;
                end
            end
        end
    end

    // Monitor: pops expected ROM reads and frame buffer writes, and checks hold during stalls
    bit         prev_stall = 0;
    logic [8:0] prev_x;
    logic [7:0] prev_y;
    logic [7:0] prev_c;
    wr_t        exp_wr;
    int         exp_a;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_we_held", int'(fb_we), 1);
                chk("stall_x_held", int'(fb_x), int'(prev_x));
                chk("stall_y_held", int'(fb_y), int'(prev_y));
                chk("stall_color_held", int'(fb_color), int'(prev_c));
            end
            prev_stall = fb_we && !fb_rdy;
            prev_x = fb_x;
            prev_y = fb_y;
            prev_c = fb_color;
            if (rom_re) begin
                if (addr_q.size() == 0) begin
                    chk("unexpected_rom_read", int'(rom_addr), -1);
                end else begin
                    exp_a = addr_q.pop_front();
                    chk("rom_addr", int'(rom_addr), exp_a);
                end
            end
            if (fb_we && fb_rdy) begin
                wr_seen++;
                if (wr_q.size() == 0) begin
                    chk("unexpected_write_x", int'(fb_x), -1);
                end else begin
                    exp_wr = wr_q.pop_front();
                    chk("fb_x", int'(fb_x), exp_wr.x);
                    chk("fb_y", int'(fb_y), exp_wr.y);
                    chk("fb_color", int'(fb_color), exp_wr.c);
                end
            end
        end
    end

    task automatic flush_all();
        addr_q.delete();
        wr_q.delete();
        stall_q.delete();
    endtask

    // Issue one sprite; poke_mid/poke_done raise start at those cycles, abort_at asserts reset at that cycle
    task automatic run_sprite(input int img, input int x, input int y,
                              input int poke_mid, input int poke_done, input int abort_at);
        int skips, writes, n, done_at, p, px, py;
        skips = 0;
        writes = 0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                addr_q.push_back(img * DIM * DIM + r * DIM + c);
                p  = int'(rom_fn(img * DIM * DIM + r * DIM + c));
                px = x + c;
                py = y + r;
                if (p != 0 && px < SW && py < SH) begin
                    wr_q.push_back('{px, py, p});
                    writes++;
                end else begin
                    skips++;
                end
            end
        end
        stall_total = 0;
        wr_seen = 0;
        n = 0;
        while (!draw_sprite_rdy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rdy_before_start", int'(draw_sprite_rdy), 1);
        draw_sprite_start = 1'b1;
        draw_sprite_image = 8'(img);
        draw_sprite_coordinates = {9'(x), 8'(y)};
        @(posedge clk);
        #1;
        draw_sprite_start = 1'b0;
        chk("rdy_low_after_accept", int'(draw_sprite_rdy), 0);
        done_at = 0;
        n = 1;
        while (done_at == 0 && n <= 4000) begin
            if (n == abort_at) begin
                rst_n = 1'b0;
                #2;
                chk("abort_rdy", int'(draw_sprite_rdy), 1);
                chk("abort_fb_we", int'(fb_we), 0);
                chk("abort_rom_re", int'(rom_re), 0);
                chk("abort_done", int'(draw_done), 0);
                chk("abort_fb_x", int'(fb_x), 0);
                flush_all();
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                last_done_at = -1;
                last_writes = wr_seen;
                return;
            end
            if (n == poke_mid || n == poke_done) begin
                draw_sprite_start = 1'b1;
                draw_sprite_image = 8'($urandom);
                draw_sprite_coordinates = 17'($urandom);
            end else begin
                draw_sprite_start = 1'b0;
            end
            @(negedge clk);
            if (draw_done) done_at = n;
            @(posedge clk);
            #1;
            n++;
        end
        draw_sprite_start = 1'b0;
        if (done_at == 0) begin
            chk("done_timeout", 0, 1);
            rst_n = 1'b0;
            #2;
            flush_all();
            rst_n = 1'b1;
        end else begin
            chk("done_cycle", done_at, 3 * skips + 4 * writes + stall_total);
            @(negedge clk);
            chk("rdy_after_done", int'(draw_sprite_rdy), 1);
            chk("done_one_pulse", int'(draw_done), 0);
            chk("write_count", wr_seen, writes);
            chk("writes_left", wr_q.size(), 0);
            chk("reads_left", addr_q.size(), 0);
            @(posedge clk);
            #1;
            chk("no_launch_rom_re", int'(rom_re), 0);
        end
        stall_q.delete();
        last_done_at = done_at;
        last_writes = wr_seen;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        draw_sprite_start = 1'b0;
        draw_sprite_image = '0;
        draw_sprite_coordinates = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", int'(draw_sprite_rdy), 1);
        chk("reset_done", int'(draw_done), 0);
        chk("reset_rom_re", int'(rom_re), 0);
        chk("reset_fb_we", int'(fb_we), 0);
        chk("reset_rom_addr", int'(rom_addr), 0);
        chk("reset_fb_x", int'(fb_x), 0);
        chk("reset_fb_y", int'(fb_y), 0);
        chk("reset_fb_color", int'(fb_color), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Solid sprite fully on screen
        rom_mode = 0;
        run_sprite(3, 10, 20, 0, 0, 0);
        chk("t1_cycles", last_done_at, 256);
        chk("t1_writes", last_writes, 64);

        // Transparent even columns
        rom_mode = 1;
        run_sprite(3, 10, 20, 0, 0, 0);
        chk("t2_cycles", last_done_at, 224);
        chk("t2_writes", last_writes, 32);

        // Bottom-right corner clipping
        rom_mode = 0;
        run_sprite(3, 316, 236, 0, 0, 0);
        chk("t3_writes", last_writes, 16);
        chk("t3_cycles", last_done_at, 208);

        // Five-cycle stall on the first write
        stall_q.push_back(5);
        run_sprite(3, 10, 20, 0, 0, 0);
        chk("t4_cycles", last_done_at, 261);
        chk("t4_writes", last_writes, 64);

        // Starts mid-draw and in the draw_done cycle are ignored
        run_sprite(3, 10, 20, 100, 256, 0);
        chk("t5_cycles", last_done_at, 256);

        // Reset while pixel 20 is being written, then a clean full sprite
        run_sprite(5, 40, 60, 0, 0, 83);
        run_sprite(7, 100, 50, 0, 0, 0);
        chk("t6_cycles", last_done_at, 256);
        chk("t6_writes", last_writes, 64);

        // Random images, positions, pixel data and stalls
        rom_mode = 2;
        for (int k = 0; k < 10; k++) begin
            rom_seed = $urandom;
            for (int w = 0; w < DIM * DIM; w++) begin
                stall_q.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
            run_sprite(int'($urandom_range(0, 255)), int'($urandom_range(0, 330)),
                       int'($urandom_range(0, 250)), 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
